alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Front-end issue/sequencing block for the 8-bit ALU datapath. Accepts one operation per valid/ready handshake, registers the operands onto the shared functional-unit operand buses, and drives the one-hot unit select consumed by the ALU output mux. It holds the select for the unit's latency, captures the mux result, and presents it with an error flag on a valid/ready output port.

## Interface
- K, 7: number of functional units. Width of `sel`. Opcodes `0..K-1` are legal.
- MUL_CYCLES, 4: cycles `sel[6]` (mult) is held before capture. Legal range is 1..15.
- clk  in  1  rising-edge clock; the block's only clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operation request valid.
- in_ready  out  1  block can accept; high only in IDLE.
- in_op  in  3  opcode: 0 AND, 1 OR, 2 XOR, 3 NOT (of a), 4 ADD, 5 SUB, 6 MUL, 7 illegal.
- in_a  in  8  operand A.
- in_b  in  8  operand B.
- opa  out  8  registered operand A to all units.
- opb  out  8  registered operand B to all units.
- sel  out  K  one-hot unit select to the output mux; all-zero when idle.
- res  in  8  mux output, sampled at capture.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  8  captured result.
- out_err  out  1  request had an illegal opcode.

## Operation
- FSM states are IDLE, EXEC and DONE. Register `cnt` is 4 bits.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`, latch `opa`←`in_a` and `opb`←`in_b`.
  - If `in_op`≥K: set `out_data`←0 and `out_err`←1, keep `sel`=0, and go to DONE.
  - Else set `sel`←(1<<`in_op`), `cnt`←(`in_op`==6 ? MUL_CYCLES-1 : 0), and go to EXEC.
- **EXEC**
  - `in_ready`=0.
  - If `cnt`==0: set `out_data`←`res`, `out_err`←0, `sel`←0, and go to DONE.
  - Else decrement `cnt`.
  - `sel`, `opa` and `opb` stay stable for the whole of EXEC.
- **DONE**
  - `out_valid`=1. `out_data` and `out_err` hold until the handshake.
  - On `out_ready`, go to IDLE.
  - `opa` and `opb` keep their last values, so units see no spurious changes.
- `sel` is one-hot or all-zero in every cycle. It never has more than one bit set.
- `in_op`, `in_a` and `in_b` are ignored when no handshake occurs.
- All arithmetic is done by the external units, truncated to 8 bits. This block never modifies `res`.

## Timing
- Reset: state IDLE, `in_ready`=1, and `sel`, `opa`, `opb`, `out_data`, `out_err`, `out_valid` all 0. Reset takes effect immediately and asynchronously.
- Reset asserted mid-EXEC or mid-DONE aborts the operation: `sel` drops to 0 at once and the pending result is discarded.
- Outputs are registered, except `in_ready` and `out_valid`, which decode the state register.
- Call the accept edge N (`in_valid`&`in_ready` sampled high).
  - Single-cycle op: `sel` is valid in cycle N+1, `res` is captured at edge N+1, and `out_valid` is high from N+1.
  - MUL: `sel[6]` is held for MUL_CYCLES cycles, `res` is captured at edge N+MUL_CYCLES, and `out_valid` is high after that edge.
  - Illegal opcode: `out_valid` is high after edge N.
- Output handshake at edge M returns the block to IDLE. `in_ready` rises after edge M, so the earliest next accept is edge M+1. There is no same-cycle turnaround.
- `out_valid` with `out_ready` held low stalls indefinitely with data stable.
- Throughput: one op per 3 cycles for single-cycle ops with `out_ready` tied high; one per MUL_CYCLES+2 for MUL.

## Test plan
The bench models the units and mux as a combinational function of `sel`, `opa` and `opb`.

- Reset then idle: `rst_n` low for 2 cycles, then high with `in_valid`=0. Expect `in_ready`=1, `sel`=0, `out_valid`=0 and all data outputs 0 for 10 cycles.
- ADD: accept op=4, a=0x3C, b=0x11 at edge N. Expect `sel`=7'b0010000 in cycle N+1. Expect `out_valid`=1, `out_data`=0x4D, `out_err`=0 after edge N+1.
- SUB wrap and NOT:
  - op=5, a=0x05, b=0x07 gives `out_data`=0xFE.
  - op=3, a=0x0F gives 0xF0.
  - Each completes with `in_ready` low throughout.
- MUL latency (MUL_CYCLES=4): op=6, a=0x12, b=0x0B.
  - `sel`=7'b1000000 for exactly 4 cycles.
  - `out_data`=0xC6 valid after edge N+4.
  - The bench toggles the model's `res` before the final cycle, and only the value in the capture cycle is taken.
- Illegal and backpressure: op=7 with a=0xAA gives `out_valid` after edge N, with `out_data`=0, `out_err`=1 and `sel` never nonzero. Then hold `out_ready`=0 for 5 cycles and check:
  - outputs stay stable;
  - `in_ready` stays 0 while `in_valid` is asserted;
  - after `out_ready`, `in_ready`=1 one cycle later.
- Reset mid-MUL: assert `rst_n` low in the 2nd EXEC cycle of a MUL. Expect `sel`=0 and `out_valid`=0 immediately, with no result emitted after release. A following ADD 0x01+0x01 returns 0x02.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - issue/sequencing front end for the 8-bit ALU datapath
// Accepts one op, drives operand buses and one-hot unit select, captures the mux result.
module alu_op_sequencer #(
  parameter int K          = 7,
  parameter int MUL_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_op,
  input  logic [7:0]   in_a,
  input  logic [7:0]   in_b,
  output logic [7:0]   opa,
  output logic [7:0]   opb,
  output logic [K-1:0] sel,
  input  logic [7:0]   res,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_data,
  output logic         out_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0]   NUM_UNITS = 4'(K);
  localparam logic [2:0]   MUL_OP    = 3'd6;
  localparam logic [3:0]   MUL_LOAD  = 4'(MUL_CYCLES - 1);
  localparam logic [K-1:0] SEL_ONE   = {{(K-1){1'b0}}, 1'b1};

  state_t     state;
  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      sel      <= '0;
      opa      <= 8'd0;
      opb      <= 8'd0;
      out_data <= 8'd0;
      out_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opa <= in_a;
            opb <= in_b;
            // Illegal opcodes never reach a unit: sel stays zero and the error is reported directly.
            if ({1'b0, in_op} >= NUM_UNITS) begin
              out_data <= 8'd0;
              out_err  <= 1'b1;
              sel      <= '0;
              state    <= DONE;
            end else begin
              sel   <= SEL_ONE << in_op;
              cnt   <= (in_op == MUL_OP) ? MUL_LOAD : 4'd0;
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          if (cnt == 4'd0) begin
            out_data <= res;
            out_err  <= 1'b0;
            sel      <= '0;
            state    <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          sel   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - randomized self-checking bench for alu_op_sequencer
// Units and mux are modelled combinationally from sel/opa/opb; results checked against op-level arithmetic.
module tb_alu_op_sequencer;
  localparam int K          = 7;
  localparam int MUL_CYCLES = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   in_op = 3'd0;
  logic [7:0]   in_a = 8'd0;
  logic [7:0]   in_b = 8'd0;
  logic [7:0]   opa;
  logic [7:0]   opb;
  logic [K-1:0] sel;
  logic [7:0]   res;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [7:0]   out_data;
  logic         out_err;
  logic         garble = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  alu_op_sequencer #(.K(K), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .opa(opa), .opb(opb), .sel(sel),
    .res(res), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err)
  );

  always #5 clk = ~clk;

  // Functional units behind the output mux; garble corrupts res outside the capture cycle.
  always_comb begin
    logic [7:0] r;
    r = 8'd0;
    if (sel[0]) r = opa & opb;
    if (sel[1]) r = opa | opb;
    if (sel[2]) r = opa ^ opb;
    if (sel[3]) r = ~opa;
    if (sel[4]) r = opa + opb;
    if (sel[5]) r = opa - opb;
    if (sel[6]) r = opa * opb;
    res = garble ? ~r : r;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_result(input int op, input int a, input int b);
    case (op)
      0: return 8'(a & b);
      1: return 8'(a | b);
      2: return 8'(a ^ b);
      3: return 8'(255 - a);
      4: return 8'((a + b) % 256);
      5: return 8'((a - b + 256) % 256);
      6: return 8'((a * b) % 256);
      default: return 8'd0;
    endcase
  endfunction

  task automatic run_op(input int op, input int a, input int b, input int ready_delay);
    int lat;
    int exp_lat;
    int exp_sel;
    logic [7:0] exp_data;
    exp_data = ref_result(op, a, b);
    exp_lat  = (op >= K) ? 0 : (op == 6) ? MUL_CYCLES : 1;
    exp_sel  = (op >= K) ? 0 : (1 << op);
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'(op); in_a = 8'(a); in_b = 8'(b);
    check("accept_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_op = 3'($urandom); in_a = 8'($urandom); in_b = 8'($urandom);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      lat++;
      garble = (lat < exp_lat);
      check("exec_sel", sel, exp_sel);
      check("exec_in_ready", in_ready, 0);
      check("exec_opa", opa, a);
      @(negedge clk);
    end
    garble = 1'b0;
    check("latency", lat, exp_lat);
    check("out_data", out_data, exp_data);
    check("out_err", out_err, (op >= K) ? 1 : 0);
    check("done_sel", sel, 0);
    check("done_opb", opb, b);
    for (int i = 0; i < ready_delay; i++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, exp_data);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("post_in_ready", in_ready, 1);
    check("post_out_valid", out_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_sel", sel, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_in_ready", in_ready, 1);
      check("idle_outs", {sel, opa, opb, out_data, out_err, out_valid}, 0);
    end

    run_op(4, 8'h3C, 8'h11, 0);
    run_op(5, 8'h05, 8'h07, 0);
    run_op(3, 8'h0F, 8'h00, 0);
    run_op(6, 8'h12, 8'h0B, 1);

    // Illegal opcode followed by a backpressure stall with in_valid held high.
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd7; in_a = 8'hAA; in_b = 8'h55;
    @(posedge clk);
    @(negedge clk);
    check("ill_valid", out_valid, 1);
    check("ill_data", out_data, 0);
    check("ill_err", out_err, 1);
    check("ill_sel", sel, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_stable", {out_valid, out_err, out_data, sel}, {1'b1, 1'b1, 8'h00, 7'd0});
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("bp_release_ready", in_ready, 1);

    // Reset in the second EXEC cycle of a MUL.
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd6; in_a = 8'h21; in_b = 8'h03;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_sel", sel, 0);
    check("abort_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_no_result", out_valid, 0);
    end
    run_op(4, 8'h01, 8'h01, 0);

    for (int i = 0; i < 40; i++) begin
      run_op($urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255),
             $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
